accel_result_sink: RTL

- Receiving end of the accelerator write interface (wrReq / wDone / wrData).
- Captures every result word pushed by the accelerator into a circular FIFO and counts completed bursts (wDone pulses).
- Exposes a registered read port for the downstream host or bench.
- The accelerator has no back-pressure, so the sink detects overflow and reports it; it never stalls the writer.

---
 rtl/accel_pkg.sv | 12 +
 rtl/accel_result_sink_if.sv | 30 +++
 rtl/accel_sink_mem.sv | 44 ++++
 rtl/accel_result_sink.sv | 94 +++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator result path.
// Holds the accelerator word width, default FIFO geometry and the result
// word type used by the sink and its users.
// Optional feature macro used by the sink: ACCEL_SINK_LAST_TAG_EN.
package accel_pkg;
  localparam int ACC_DATA_W = 21;  // shared with the accelerator
  localparam int DEPTH_DEF  = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int DCNT_W_DEF = 8;

  typedef logic [ACC_DATA_W-1:0] acc_word_t;
endpackage

// File: rtl/accel_result_sink_if.sv
// Accelerator-to-sink bus: write side (wrReq/wrData/wDone) and the
// registered read side (rdReq/rdData/rdValid[/rdLast]).
//   master : accelerator / consumer side (drives requests, sees read data)
//   slave  : accel_result_sink
// Macro ACCEL_SINK_LAST_TAG_EN adds rdLast (end-of-burst tag on read data).
interface accel_result_sink_if
  import accel_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W
);
  logic              wrReq;
  logic [DATA_W-1:0] wrData;
  logic              wDone;
  logic              rdReq;
  logic [DATA_W-1:0] rdData;
  logic              rdValid;
`ifdef ACCEL_SINK_LAST_TAG_EN
  logic              rdLast;

  modport master (output wrReq, wrData, wDone, rdReq,
                  input  rdData, rdValid, rdLast);
  modport slave  (input  wrReq, wrData, wDone, rdReq,
                  output rdData, rdValid, rdLast);
`else
  modport master (output wrReq, wrData, wDone, rdReq,
                  input  rdData, rdValid);
  modport slave  (input  wrReq, wrData, wDone, rdReq,
                  output rdData, rdValid);
`endif
endinterface

// File: rtl/accel_sink_mem.sv
// DEPTH x W storage for the result sink: one write port and one
// synchronous read port whose output register resets to 0 and holds its
// value when no read is requested.
// With ACCEL_SINK_LAST_TAG_EN a tag port sets the MSB (last bit) of an
// already-written entry; the top never asserts it together with we.
// Ports: clk, rst (async low), we/waddr/wdata, [tag_set/tag_addr],
//        re/raddr, rdata.
module accel_sink_mem
  import accel_pkg::*;
#(
  parameter int W      = ACC_DATA_W,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
`ifdef ACCEL_SINK_LAST_TAG_EN
  input  logic              tag_set,
  input  logic [ADDR_W-1:0] tag_addr,
`endif
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);
  logic [W-1:0] mem [DEPTH];

  // storage is not reset; contents before the first write are don't-care
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
`ifdef ACCEL_SINK_LAST_TAG_EN
    if (tag_set) mem[tag_addr][W-1] <= 1'b1;
`endif
  end

  // read sees the pre-edge contents, so a same-cycle write to the read
  // slot (full FIFO, read+write) returns the old word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/accel_result_sink.sv
// Receiving end of the accelerator write interface. Every accepted word
// goes into a circular FIFO; wDone pulses are counted in doneCnt. The
// writer is never stalled: a write to a full FIFO without a concurrent
// read is dropped and raises the sticky ovf flag (cleared by ovfClr,
// a same-cycle overflow wins).
// Ports: clk, rst (async low), bus (accel_result_sink_if.slave),
//        ovfClr, empty, full, count, ovf, doneCnt.
// Macro ACCEL_SINK_LAST_TAG_EN: store a last bit per entry and return it
// on bus.rdLast alongside rdData.
module accel_result_sink
  import accel_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DCNT_W = DCNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  accel_result_sink_if.slave  bus,
  input  logic                ovfClr,
  output logic                empty,
  output logic                full,
  output logic [ADDR_W:0]     count,
  output logic                ovf,
  output logic [DCNT_W-1:0]   doneCnt
);
`ifdef ACCEL_SINK_LAST_TAG_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              rd_acc, wr_acc;
  logic [MW-1:0]     mem_wdata, mem_rdata;

  assign empty  = (count == '0);
  assign full   = (count == (ADDR_W+1)'(DEPTH));
  assign rd_acc = bus.rdReq & ~empty;
  // a read on a full FIFO frees the slot the write lands in
  assign wr_acc = bus.wrReq & (~full | rd_acc);

`ifdef ACCEL_SINK_LAST_TAG_EN
  logic              tag_set;
  logic [ADDR_W-1:0] last_ptr;

  assign last_ptr  = wr_ptr - 1'b1;
  // wDone with no word this cycle closes the burst on the newest entry,
  // unless that entry is leaving the FIFO right now
  assign tag_set   = bus.wDone & ~wr_acc & ~empty & ~(rd_acc & (rd_ptr == last_ptr));
  assign mem_wdata = {bus.wDone, bus.wrData};
  assign bus.rdLast = mem_rdata[MW-1];
`else
  assign mem_wdata = bus.wrData;
`endif
  assign bus.rdData = mem_rdata[DATA_W-1:0];

  accel_sink_mem #(.W(MW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .we       (wr_acc),
    .waddr    (wr_ptr),
    .wdata    (mem_wdata),
`ifdef ACCEL_SINK_LAST_TAG_EN
    .tag_set  (tag_set),
    .tag_addr (last_ptr),
`endif
    .re       (rd_acc),
    .raddr    (rd_ptr),
    .rdata    (mem_rdata)
  );

  // pointers wrap naturally since DEPTH == 2**ADDR_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus.rdValid <= 1'b0;
      ovf         <= 1'b0;
      doneCnt     <= '0;
    end else begin
      bus.rdValid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc & ~rd_acc)      count <= count + 1'b1;
      else if (rd_acc & ~wr_acc) count <= count - 1'b1;
      if (bus.wrReq & ~wr_acc) ovf <= 1'b1;
      else if (ovfClr)         ovf <= 1'b0;
      if (bus.wDone) doneCnt <= doneCnt + 1'b1;
    end
  end
endmodule
